// File: rtl/struct_s.sv
`default_nettype none
// struct_s: shared DDR read-request types and arbiter defaults. Rev 1.0
package struct_s;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ddr_rd_t;

  // Tag records which requester issued an outstanding read: 0 = PDU mover, 1 = CPU/debug.
  typedef logic ddr_rd_tag_t;

  localparam int MAX_OUTSTANDING_DEFAULT = 450;

endpackage
`default_nettype wire

// File: rtl/ddr_rd_req_arbiter_if.sv
`default_nettype none
// ddr_rd_req_arbiter_if: requester, DDR request and DDR response signal bundle. Rev 1.0
interface ddr_rd_req_arbiter_if;
  import struct_s::*;

  ddr_rd_t       req0_data;
  ddr_rd_t       req1_data;
  logic          req0_valid;
  logic          req1_valid;
  logic          req0_ready;
  logic          req1_ready;
  ddr_rd_t       ddr_rd_req_data;
  logic          ddr_rd_req_valid;
  logic          ddr_rd_req_almost_full;
  logic [511:0]  ddr_rd_resp_data;
  logic          ddr_rd_resp_valid;
  logic          ddr_rd_resp_ready;
  logic [511:0]  resp0_data;
  logic [511:0]  resp1_data;
  logic          resp0_valid;
  logic          resp1_valid;
  logic          resp0_ready;
  logic          resp1_ready;

  // Environment side: requesters, DDR controller and response FIFO.
  modport master (
    output req0_data, req1_data, req0_valid, req1_valid,
    input  req0_ready, req1_ready,
    input  ddr_rd_req_data, ddr_rd_req_valid,
    output ddr_rd_req_almost_full,
    output ddr_rd_resp_data, ddr_rd_resp_valid,
    input  ddr_rd_resp_ready,
    input  resp0_data, resp1_data, resp0_valid, resp1_valid,
    output resp0_ready, resp1_ready
  );

  modport slave (
    input  req0_data, req1_data, req0_valid, req1_valid,
    output req0_ready, req1_ready,
    output ddr_rd_req_data, ddr_rd_req_valid,
    input  ddr_rd_req_almost_full,
    input  ddr_rd_resp_data, ddr_rd_resp_valid,
    output ddr_rd_resp_ready,
    output resp0_data, resp1_data, resp0_valid, resp1_valid,
    input  resp0_ready, resp1_ready
  );

endinterface
`default_nettype wire

// File: rtl/ddr_rd_tag_fifo.sv
`default_nettype none
// ddr_rd_tag_fifo: TAG_DEPTH x 1-bit circular buffer of requester tags, push and pop in one cycle. Rev 1.0
module ddr_rd_tag_fifo
  import struct_s::*;
#(
  parameter int TAG_DEPTH = 512
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        push,
  input  ddr_rd_tag_t push_tag,
  input  logic        pop,
  output ddr_rd_tag_t head_tag,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  ddr_rd_tag_t  r_mem [TAG_DEPTH];
  logic         w_push;
  logic         w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers carry one extra wrap bit so equal indices can mean either full or empty.
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign head_tag = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_tag;
  end

endmodule
`default_nettype wire

// File: rtl/ddr_rd_req_arbiter.sv
`default_nettype none
// ddr_rd_req_arbiter: round-robin, credit-limited DDR read-request arbiter with in-order response steering.
// Optional DDR_RD_ARB_STATS_EN adds stat_grant0/stat_grant1/stat_stall counters. Rev 1.0
module ddr_rd_req_arbiter
  import struct_s::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int TAG_DEPTH       = 512,
  parameter int CNT_W           = 10
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  ddr_rd_req_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     credits,
  output logic                 err_orphan_resp
`ifdef DDR_RD_ARB_STATS_EN
  ,
  output logic [31:0]          stat_grant0,
  output logic [31:0]          stat_grant1,
  output logic [31:0]          stat_stall
`endif
);

  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CREDIT_ONE = CNT_W'(1);

  logic             r_last_grant;
  logic             r_req_valid;
  ddr_rd_t          r_req_data;
  logic [CNT_W-1:0] r_credits;
  logic             r_err_orphan;

  logic             w_can_issue;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant;
  logic             w_tag_full;
  logic             w_tag_empty;
  ddr_rd_tag_t      w_head;
  logic             w_head_ready;
  logic             w_resp_pop;

  // almost_full is looked at in the grant cycle only, so one more request may follow its assertion.
  assign w_can_issue = ~bus.ddr_rd_req_almost_full & (r_credits != '0) & ~w_tag_full;
  assign w_grant0    = w_can_issue & bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1    = w_can_issue & bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_grant     = w_grant0 | w_grant1;

  assign bus.req0_ready       = w_grant0;
  assign bus.req1_ready       = w_grant1;
  assign bus.ddr_rd_req_valid = r_req_valid;
  assign bus.ddr_rd_req_data  = r_req_data;

  // Responses return in issue order, so the oldest tag names the destination.
  assign w_head_ready          = w_head ? bus.resp1_ready : bus.resp0_ready;
  assign bus.resp0_data        = bus.ddr_rd_resp_data;
  assign bus.resp1_data        = bus.ddr_rd_resp_data;
  assign bus.resp0_valid       = bus.ddr_rd_resp_valid & ~w_tag_empty & ~w_head;
  assign bus.resp1_valid       = bus.ddr_rd_resp_valid & ~w_tag_empty & w_head;
  assign bus.ddr_rd_resp_ready = w_tag_empty | w_head_ready;
  assign w_resp_pop            = bus.ddr_rd_resp_valid & ~w_tag_empty & w_head_ready;

  assign credits         = r_credits;
  assign err_orphan_resp = r_err_orphan;

  ddr_rd_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .push     (w_grant),
    .push_tag (w_grant1),
    .pop      (w_resp_pop),
    .head_tag (w_head),
    .full     (w_tag_full),
    .empty    (w_tag_empty)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_req_valid  <= 1'b0;
      r_req_data   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_req_valid <= w_grant;
      if (w_grant) begin
        r_req_data   <= w_grant1 ? bus.req1_data : bus.req0_data;
        r_last_grant <= w_grant1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_credits <= CREDIT_MAX;
    end else begin
      case ({w_grant, w_resp_pop})
        2'b10:   r_credits <= r_credits - CREDIT_ONE;
        2'b01:   if (r_credits != CREDIT_MAX) r_credits <= r_credits + CREDIT_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // A response with nothing outstanding is consumed and flagged; credits stay put.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_err_orphan <= 1'b0;
    end else if (bus.ddr_rd_resp_valid && w_tag_empty) begin
      r_err_orphan <= 1'b1;
    end
  end

  a_credit_overflow : assert property (@(posedge Clk) disable iff (!Rst_n)
    !(w_resp_pop && !w_grant && (r_credits == CREDIT_MAX)));

`ifdef DDR_RD_ARB_STATS_EN
  logic [31:0] r_stat_grant0;
  logic [31:0] r_stat_grant1;
  logic [31:0] r_stat_stall;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_stat_grant0 <= '0;
      r_stat_grant1 <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_grant0) r_stat_grant0 <= r_stat_grant0 + 32'd1;
      if (w_grant1) r_stat_grant1 <= r_stat_grant1 + 32'd1;
      if ((bus.req0_valid | bus.req1_valid) & ~w_grant) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_grant0 = r_stat_grant0;
  assign stat_grant1 = r_stat_grant1;
  assign stat_stall  = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_req_arbiter.sv
`default_nettype none
// tb_ddr_rd_req_arbiter: scoreboard bench for ddr_rd_req_arbiter; define DDR_RD_ARB_STATS_EN to also cover the stat counters.
module tb_ddr_rd_req_arbiter;
  import struct_s::*;

  localparam int MAXO      = 450;
  localparam int TAG_DEPTH = 512;
  localparam int CNT_W     = 10;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [CNT_W-1:0] credits;
  logic             err_orphan_resp;
`ifdef DDR_RD_ARB_STATS_EN
  logic [31:0]      stat_grant0;
  logic [31:0]      stat_grant1;
  logic [31:0]      stat_stall;
`endif

  ddr_rd_req_arbiter_if bus();

  ddr_rd_req_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .TAG_DEPTH       (TAG_DEPTH),
    .CNT_W           (CNT_W)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .bus             (bus),
    .credits         (credits),
    .err_orphan_resp (err_orphan_resp)
`ifdef DDR_RD_ARB_STATS_EN
    ,
    .stat_grant0     (stat_grant0),
    .stat_grant1     (stat_grant1),
    .stat_stall      (stat_stall)
`endif
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model and scoreboards
  int           m_credits;
  bit           m_last;
  bit           m_tags[$];
  ddr_rd_t      exp_req_q[$];
  bit           mg0, mg1, mpop, morphan;
  int           n_g0, n_g1, n_stall;

  // DUT combinational outputs captured mid-cycle
  logic         obs_r0, obs_r1, obs_rv0, obs_rv1, obs_rrdy;
  logic [511:0] obs_rd0, obs_rd1;

  function automatic ddr_rd_t rand_req();
    ddr_rd_t r;
    r.addr = $urandom();
    r.len  = 8'($urandom());
    return r;
  endfunction

  function automatic logic [511:0] rand_resp();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data = '0;
    bus.req1_data = '0;
    bus.ddr_rd_req_almost_full = 1'b0;
    bus.ddr_rd_resp_valid = 1'b0;
    bus.ddr_rd_resp_data = '0;
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    m_credits = MAXO;
    m_last = 1'b1;
    m_tags.delete();
    exp_req_q.delete();
    n_g0 = 0;
    n_g1 = 0;
    n_stall = 0;
  endtask

  // One clock: predict from the model, capture DUT mid-cycle, then advance model state.
  task automatic cycle();
    bit can;
    @(negedge Clk);
    can = !bus.ddr_rd_req_almost_full && (m_credits != 0) && (m_tags.size() < TAG_DEPTH);
    mg0 = can && bus.req0_valid && (!bus.req1_valid || m_last);
    mg1 = can && bus.req1_valid && (!bus.req0_valid || !m_last);
    mpop = bus.ddr_rd_resp_valid && (m_tags.size() != 0) &&
           (m_tags[0] ? bus.resp1_ready : bus.resp0_ready);
    morphan = bus.ddr_rd_resp_valid && (m_tags.size() == 0);
    if (mg0) exp_req_q.push_back(bus.req0_data);
    else if (mg1) exp_req_q.push_back(bus.req1_data);
    obs_r0 = bus.req0_ready;
    obs_r1 = bus.req1_ready;
    obs_rv0 = bus.resp0_valid;
    obs_rv1 = bus.resp1_valid;
    obs_rrdy = bus.ddr_rd_resp_ready;
    obs_rd0 = bus.resp0_data;
    obs_rd1 = bus.resp1_data;
    if ((bus.req0_valid || bus.req1_valid) && !(mg0 || mg1)) n_stall++;
    @(posedge Clk);
    #1;
    if (mg0 || mg1) begin
      m_tags.push_back(mg1);
      m_credits--;
      m_last = mg1;
    end
    if (mg0) n_g0++;
    if (mg1) n_g1++;
    if (mpop) begin
      void'(m_tags.pop_front());
      m_credits++;
    end
  endtask

  task automatic test_reset();
    ddr_rd_t exp;
    apply_reset();
    checks++;
    if (credits !== 10'd450) begin failures++; $display("FAIL reset_credits: got %0d expected 450", credits); end
    checks++;
    if (bus.ddr_rd_req_valid !== 1'b0 || bus.ddr_rd_req_data !== '0) begin
      failures++; $display("FAIL reset_req_out: got valid=%b data=%h expected 0/0", bus.ddr_rd_req_valid, bus.ddr_rd_req_data);
    end
    checks++;
    if (err_orphan_resp !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err_orphan_resp); end
    bus.ddr_rd_resp_valid = 1'b1;
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0 || bus.ddr_rd_resp_ready !== 1'b1) begin
      failures++; $display("FAIL reset_resp: got v0=%b v1=%b rdy=%b expected 0 0 1", bus.resp0_valid, bus.resp1_valid, bus.ddr_rd_resp_ready);
    end
    bus.ddr_rd_resp_valid = 1'b0;
    // Both request together straight out of reset: port 0 must win.
    bus.req0_valid = 1'b1; bus.req0_data = rand_req();
    bus.req1_valid = 1'b1; bus.req1_data = rand_req();
    cycle();
    checks++;
    if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin failures++; $display("FAIL reset_first_grant: got r0=%b r1=%b expected 1 0", obs_r0, obs_r1); end
    exp = exp_req_q.pop_front();
    checks++;
    if (bus.ddr_rd_req_valid !== 1'b1 || bus.ddr_rd_req_data !== exp) begin
      failures++; $display("FAIL reset_first_req: got v=%b d=%h expected 1 %h", bus.ddr_rd_req_valid, bus.ddr_rd_req_data, exp);
    end
  endtask

  task automatic test_single_port();
    ddr_rd_t exp;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1; bus.req0_data = rand_req();
      cycle();
      checks++;
      if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin failures++; $display("FAIL single_ready[%0d]: got r0=%b r1=%b expected 1 0", i, obs_r0, obs_r1); end
      exp = exp_req_q.pop_front();
      checks++;
      if (bus.ddr_rd_req_valid !== 1'b1 || bus.ddr_rd_req_data !== exp) begin
        failures++; $display("FAIL single_req[%0d]: got v=%b d=%h expected 1 %h", i, bus.ddr_rd_req_valid, bus.ddr_rd_req_data, exp);
      end
    end
    idle();
    cycle();
    checks++;
    if (bus.ddr_rd_req_valid !== 1'b0) begin failures++; $display("FAIL single_valid_pulse: got %b expected 0", bus.ddr_rd_req_valid); end
    checks++;
    if (credits !== 10'd446) begin failures++; $display("FAIL single_credits: got %0d expected 446", credits); end
    // almost_full blocks grants, then releasing it lets port 1 through.
    bus.req1_valid = 1'b1; bus.req1_data = rand_req();
    bus.ddr_rd_req_almost_full = 1'b1;
    repeat (2) begin
      cycle();
      checks++;
      if (obs_r1 !== 1'b0 || bus.ddr_rd_req_valid !== 1'b0) begin
        failures++; $display("FAIL almost_full_block: got r1=%b v=%b expected 0 0", obs_r1, bus.ddr_rd_req_valid);
      end
    end
    bus.ddr_rd_req_almost_full = 1'b0;
    cycle();
    checks++;
    if (obs_r1 !== 1'b1 || !mg1) begin failures++; $display("FAIL almost_full_release: got r1=%b expected 1", obs_r1); end
    if (mg1) exp = exp_req_q.pop_front();
    checks++;
    if (bus.ddr_rd_req_data !== exp || credits !== 10'd445) begin
      failures++; $display("FAIL almost_full_req: got d=%h credits=%0d expected %h 445", bus.ddr_rd_req_data, credits, exp);
    end
    idle();
  endtask

  task automatic test_round_robin();
    ddr_rd_t exp;
    apply_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req0_data = rand_req();
      bus.req1_data = rand_req();
      cycle();
      checks++;
      if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1)) begin
        failures++; $display("FAIL rr_order[%0d]: got r0=%b r1=%b expected port %0d", i, obs_r0, obs_r1, i % 2);
      end
      exp = exp_req_q.pop_front();
      checks++;
      if (bus.ddr_rd_req_valid !== 1'b1 || bus.ddr_rd_req_data !== exp) begin
        failures++; $display("FAIL rr_req[%0d]: got v=%b d=%h expected 1 %h", i, bus.ddr_rd_req_valid, bus.ddr_rd_req_data, exp);
      end
    end
    idle();
    checks++;
    if (credits !== 10'd444) begin failures++; $display("FAIL rr_credits: got %0d expected 444", credits); end
  endtask

  task automatic test_credit_exhaust();
    ddr_rd_t exp;
    int grants;
    apply_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      bus.req0_data = rand_req();
      cycle();
      if (mg0) exp = exp_req_q.pop_front();
      checks++;
      if (obs_r0 !== 1'b1 || bus.ddr_rd_req_data !== exp) begin
        failures++; $display("FAIL exhaust_issue[%0d]: got r0=%b d=%h expected 1 %h", i, obs_r0, bus.ddr_rd_req_data, exp);
      end
    end
    checks++;
    if (credits !== 10'd0) begin failures++; $display("FAIL exhaust_credits: got %0d expected 0", credits); end
    bus.req1_valid = 1'b1;
    repeat (3) begin
      cycle();
      checks++;
      if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin failures++; $display("FAIL exhaust_blocked: got r0=%b r1=%b expected 0 0", obs_r0, obs_r1); end
    end
    bus.ddr_rd_resp_valid = 1'b1;
    bus.ddr_rd_resp_data = rand_resp();
    bus.resp0_ready = 1'b1;
    cycle();
    checks++;
    if (obs_rv0 !== 1'b1 || obs_rrdy !== 1'b1 || obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
      failures++; $display("FAIL exhaust_return: got v0=%b rdy=%b r0=%b r1=%b expected 1 1 0 0", obs_rv0, obs_rrdy, obs_r0, obs_r1);
    end
    bus.ddr_rd_resp_valid = 1'b0;
    grants = 0;
    repeat (4) begin
      cycle();
      if (obs_r0 === 1'b1 || obs_r1 === 1'b1) grants++;
      if (mg0 || mg1) void'(exp_req_q.pop_front());
    end
    checks++;
    if (grants !== 1) begin failures++; $display("FAIL exhaust_one_grant: got %0d grants expected 1", grants); end
    checks++;
    if (credits !== 10'd0) begin failures++; $display("FAIL exhaust_credits_end: got %0d expected 0", credits); end
    idle();
  endtask

  task automatic test_resp_order();
    bit exp_port [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [511:0] d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = !exp_port[i]; bus.req0_data = rand_req();
      bus.req1_valid = exp_port[i];  bus.req1_data = rand_req();
      cycle();
      void'(exp_req_q.pop_front());
      checks++;
      if (obs_r0 !== !exp_port[i] || obs_r1 !== exp_port[i]) begin
        failures++; $display("FAIL order_issue[%0d]: got r0=%b r1=%b expected port %0d", i, obs_r0, obs_r1, exp_port[i]);
      end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      d = rand_resp();
      bus.ddr_rd_resp_valid = 1'b1;
      bus.ddr_rd_resp_data = d;
      if (k == 1) begin
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b0;
        repeat (3) begin
          cycle();
          checks++;
          if (obs_rv1 !== 1'b1 || obs_rv0 !== 1'b0 || obs_rrdy !== 1'b0) begin
            failures++; $display("FAIL order_hold: got v0=%b v1=%b rdy=%b expected 0 1 0", obs_rv0, obs_rv1, obs_rrdy);
          end
        end
        checks++;
        if (credits !== 10'd447) begin failures++; $display("FAIL order_hold_credits: got %0d expected 447", credits); end
      end
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      cycle();
      checks++;
      if (obs_rv0 !== !exp_port[k] || obs_rv1 !== exp_port[k] || obs_rrdy !== 1'b1 ||
          (exp_port[k] ? obs_rd1 : obs_rd0) !== d) begin
        failures++; $display("FAIL order_deliver[%0d]: got v0=%b v1=%b rdy=%b expected port %0d", k, obs_rv0, obs_rv1, obs_rrdy, exp_port[k]);
      end
    end
    idle();
    checks++;
    if (credits !== 10'd450 || err_orphan_resp !== 1'b0 || m_tags.size() != 0) begin
      failures++; $display("FAIL order_end: got credits=%0d err=%b expected 450 0", credits, err_orphan_resp);
    end
  endtask

  task automatic test_orphan();
    bus.ddr_rd_resp_valid = 1'b1;
    bus.ddr_rd_resp_data = rand_resp();
    cycle();
    checks++;
    if (obs_rrdy !== 1'b1 || obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
      failures++; $display("FAIL orphan_drop: got rdy=%b v0=%b v1=%b expected 1 0 0", obs_rrdy, obs_rv0, obs_rv1);
    end
    idle();
    repeat (3) cycle();
    checks++;
    if (err_orphan_resp !== 1'b1 || credits !== 10'd450) begin
      failures++; $display("FAIL orphan_sticky: got err=%b credits=%0d expected 1 450", err_orphan_resp, credits);
    end
    // Reset mid-flight: the returning response becomes an orphan.
    apply_reset();
    bus.req1_valid = 1'b1; bus.req1_data = rand_req();
    repeat (2) cycle();
    exp_req_q.delete();
    apply_reset();
    checks++;
    if (err_orphan_resp !== 1'b0 || credits !== 10'd450) begin
      failures++; $display("FAIL midreset_clear: got err=%b credits=%0d expected 0 450", err_orphan_resp, credits);
    end
    bus.ddr_rd_resp_valid = 1'b1;
    bus.resp1_ready = 1'b1;
    cycle();
    idle();
    checks++;
    if (obs_rv1 !== 1'b0 || err_orphan_resp !== 1'b1 || credits !== 10'd450) begin
      failures++; $display("FAIL midreset_orphan: got v1=%b err=%b credits=%0d expected 0 1 450", obs_rv1, err_orphan_resp, credits);
    end
  endtask

  task automatic test_simultaneous();
    ddr_rd_t exp;
    apply_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < MAXO - 10; i++) begin
      bus.req0_data = rand_req();
      cycle();
      if (mg0) void'(exp_req_q.pop_front());
    end
    bus.ddr_rd_req_almost_full = 1'b1;
    repeat (2) cycle();
    bus.ddr_rd_req_almost_full = 1'b0;
    checks++;
    if (credits !== 10'd10) begin failures++; $display("FAIL simul_pre_credits: got %0d expected 10", credits); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = rand_req();
    bus.ddr_rd_resp_valid = 1'b1; bus.ddr_rd_resp_data = rand_resp();
    bus.resp0_ready = 1'b1;
    cycle();
    checks++;
    if (obs_r1 !== 1'b1 || obs_rrdy !== 1'b1 || obs_rv0 !== 1'b1 || !(mg1 && mpop)) begin
      failures++; $display("FAIL simul_handshakes: got r1=%b rdy=%b v0=%b expected 1 1 1", obs_r1, obs_rrdy, obs_rv0);
    end
    if (mg1) exp = exp_req_q.pop_front();
    checks++;
    if (credits !== 10'd10 || bus.ddr_rd_req_valid !== 1'b1 || bus.ddr_rd_req_data !== exp) begin
      failures++; $display("FAIL simul_credits: got credits=%0d v=%b d=%h expected 10 1 %h", credits, bus.ddr_rd_req_valid, bus.ddr_rd_req_data, exp);
    end
    idle();
    cycle();
`ifdef DDR_RD_ARB_STATS_EN
    checks++;
    if (stat_grant0 !== 32'd440 || stat_grant0 !== 32'(n_g0)) begin failures++; $display("FAIL stat_grant0: got %0d expected 440", stat_grant0); end
    checks++;
    if (stat_grant1 !== 32'd1 || stat_grant1 !== 32'(n_g1)) begin failures++; $display("FAIL stat_grant1: got %0d expected 1", stat_grant1); end
    checks++;
    if (stat_stall !== 32'd2 || stat_stall !== 32'(n_stall)) begin failures++; $display("FAIL stat_stall: got %0d expected 2", stat_stall); end
`endif
  endtask

  initial begin
    idle();
    test_reset();
    test_single_port();
    test_round_robin();
    test_credit_exhaust();
    test_resp_order();
    test_orphan();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
